dmem_arbiter: RTL and testbench



---
 rtl/dmem_arbiter_if.sv | 52 +++++
 rtl/dmem_arbiter.sv | 154 +++++++++++++++
 tb/tb_dmem_arbiter.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the memory stage / UART loader requesters and data_memory.
// The arbiter takes the slave side; the driving environment takes the master side.
interface dmem_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  cpu_req;
    logic                  cpu_we;
    logic [ADDR_WIDTH-1:0] cpu_addr;
    logic [DATA_WIDTH-1:0] cpu_wdata;
    logic                  cpu_gnt;
    logic                  cpu_stall;
    logic                  cpu_rvalid;
    logic [DATA_WIDTH-1:0] cpu_rdata;

    logic                  ld_req;
    logic                  ld_we;
    logic [ADDR_WIDTH-1:0] ld_addr;
    logic [DATA_WIDTH-1:0] ld_wdata;
    logic                  ld_lock;
    logic                  ld_gnt;
    logic                  ld_rvalid;
    logic [DATA_WIDTH-1:0] ld_rdata;

    logic                  locked;

    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic                  mem_write;
    logic                  mem_read;
    logic [DATA_WIDTH-1:0] mem_rdata;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  ld_req, ld_we, ld_addr, ld_wdata, ld_lock,
        input  mem_rdata,
        output cpu_gnt, cpu_stall, cpu_rvalid, cpu_rdata,
        output ld_gnt, ld_rvalid, ld_rdata,
        output locked,
        output mem_addr, mem_wdata, mem_write, mem_read
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output ld_req, ld_we, ld_addr, ld_wdata, ld_lock,
        output mem_rdata,
        input  cpu_gnt, cpu_stall, cpu_rvalid, cpu_rdata,
        input  ld_gnt, ld_rvalid, ld_rdata,
        input  locked,
        input  mem_addr, mem_wdata, mem_write, mem_read
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Shares the single-ported data memory between the CPU memory stage and the UART loader,
// with anti-starvation for the loader and an exclusive lock mode for boot/upload.
module dmem_arbiter #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic           clk,
    input  logic           rst,
    dmem_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_ARB    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_LD   = 2'd2
    } owner_t;

    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

    state_t                state_q, state_d;
    logic [3:0]            starve_q, starve_d;
    owner_t                rd_owner_q, rd_owner_d;
    logic [DATA_WIDTH-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DATA_WIDTH-1:0] ld_rdata_q, ld_rdata_d;

    logic                  cpu_gnt;
    logic                  ld_gnt;
    logic                  sel_we;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;

    // Grants are suppressed while rst is high so nothing reaches memory during reset.
    always_comb begin
        cpu_gnt = 1'b0;
        ld_gnt  = 1'b0;
        if (!rst) begin
            case (state_q)
                ST_ARB: begin
                    if (bus.cpu_req && bus.ld_req) begin
                        if (starve_q == STARVE_MAX) begin
                            ld_gnt = 1'b1;
                        end else begin
                            cpu_gnt = 1'b1;
                        end
                    end else begin
                        cpu_gnt = bus.cpu_req;
                        ld_gnt  = bus.ld_req;
                    end
                end
                ST_DRAIN, ST_LOCKED: begin
                    ld_gnt = bus.ld_req;
                end
                default: begin
                    cpu_gnt = 1'b0;
                    ld_gnt  = 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        if (cpu_gnt) begin
            sel_we    = bus.cpu_we;
            sel_addr  = bus.cpu_addr;
            sel_wdata = bus.cpu_wdata;
        end else if (ld_gnt) begin
            sel_we    = bus.ld_we;
            sel_addr  = bus.ld_addr;
            sel_wdata = bus.ld_wdata;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_ARB:    if (bus.ld_lock) state_d = ST_DRAIN;
            ST_DRAIN:  state_d = bus.ld_lock ? ST_LOCKED : ST_ARB;
            ST_LOCKED: if (!bus.ld_lock) state_d = ST_ARB;
            default:   state_d = ST_ARB;
        endcase
    end

    // LD can only lose in ARB, so the counter is naturally zero on leaving LOCKED.
    always_comb begin
        starve_d = 4'd0;
        if (bus.ld_req && !ld_gnt) begin
            starve_d = (starve_q >= STARVE_MAX) ? STARVE_MAX : starve_q + 4'd1;
        end
    end

    always_comb begin
        rd_owner_d = OWN_NONE;
        if (cpu_gnt && !bus.cpu_we) begin
            rd_owner_d = OWN_CPU;
        end else if (ld_gnt && !bus.ld_we) begin
            rd_owner_d = OWN_LD;
        end
    end

    // Only the owning port sees fresh memory data; the other keeps its previous value.
    always_comb begin
        cpu_rdata_d = cpu_rdata_q;
        ld_rdata_d  = ld_rdata_q;
        if (rd_owner_q == OWN_CPU) begin
            cpu_rdata_d = bus.mem_rdata;
        end
        if (rd_owner_q == OWN_LD) begin
            ld_rdata_d = bus.mem_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_ARB;
            starve_q    <= 4'd0;
            rd_owner_q  <= OWN_NONE;
            cpu_rdata_q <= '0;
            ld_rdata_q  <= '0;
        end else begin
            state_q     <= state_d;
            starve_q    <= starve_d;
            rd_owner_q  <= rd_owner_d;
            cpu_rdata_q <= cpu_rdata_d;
            ld_rdata_q  <= ld_rdata_d;
        end
    end

    assign bus.cpu_gnt    = cpu_gnt;
    assign bus.cpu_stall  = bus.cpu_req & ~cpu_gnt;
    assign bus.cpu_rvalid = (rd_owner_q == OWN_CPU);
    assign bus.cpu_rdata  = cpu_rdata_d;

    assign bus.ld_gnt     = ld_gnt;
    assign bus.ld_rvalid  = (rd_owner_q == OWN_LD);
    assign bus.ld_rdata   = ld_rdata_d;

    assign bus.locked     = (state_q == ST_LOCKED);

    assign bus.mem_addr   = sel_addr;
    assign bus.mem_wdata  = sel_wdata;
    assign bus.mem_read   = (cpu_gnt | ld_gnt) & ~sel_we;
    assign bus.mem_write  = (cpu_gnt | ld_gnt) & sel_we;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: a behavioural data_memory plus a reference copy of memory
// whose read results are queued per port when a read is issued and popped on return.
module tb_dmem_arbiter;

    logic clk;
    logic rst;
    logic preload;

    int test_count;
    int fail_count;

    logic [31:0] tb_mem  [0:63];
    logic [31:0] ref_mem [0:63];
    logic [31:0] cpu_q[$];
    logic [31:0] ld_q[$];

    dmem_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    dmem_arbiter #(
        .ADDR_WIDTH  (32),
        .DATA_WIDTH  (32),
        .STARVE_LIMIT(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(input int idx);
        if (idx == 8) return 32'h1122_3344;
        return 32'hC0DE_0000 | 32'(idx * 4);
    endfunction

    // Behavioural data_memory: one-cycle read latency, write commits at the edge.
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 64; i++) tb_mem[i] <= init_word(i);
        end else begin
            if (bus.mem_write) tb_mem[bus.mem_addr[7:2]] <= bus.mem_wdata;
            if (bus.mem_read) bus.mem_rdata <= tb_mem[bus.mem_addr[7:2]];
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        test_count++;
        if (actual !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(
        input string       tag,
        input logic        c_req,
        input logic        c_we,
        input logic [31:0] c_addr,
        input logic [31:0] c_wdata,
        input logic        l_req,
        input logic        l_we,
        input logic [31:0] l_addr,
        input logic [31:0] l_wdata,
        input logic        l_lock,
        input logic        exp_cgnt,
        input logic        exp_lgnt,
        input logic        exp_locked,
        input logic        rst_at_edge
    );
        logic [31:0] exp_addr;
        logic [31:0] exp_wdata;
        logic [5:0]  c_idx;
        logic [5:0]  l_idx;
        bus.cpu_req   = c_req;
        bus.cpu_we    = c_we;
        bus.cpu_addr  = c_addr;
        bus.cpu_wdata = c_wdata;
        bus.ld_req    = l_req;
        bus.ld_we     = l_we;
        bus.ld_addr   = l_addr;
        bus.ld_wdata  = l_wdata;
        bus.ld_lock   = l_lock;
        c_idx = c_addr[7:2];
        l_idx = l_addr[7:2];
        @(negedge clk);
        if (cpu_q.size() > 0) begin
            checkOutput({tag, "/cpu_rvalid"}, 32'(bus.cpu_rvalid), 32'd1);
            checkOutput({tag, "/cpu_rdata"}, bus.cpu_rdata, cpu_q.pop_front());
        end else begin
            checkOutput({tag, "/cpu_rvalid"}, 32'(bus.cpu_rvalid), 32'd0);
        end
        if (ld_q.size() > 0) begin
            checkOutput({tag, "/ld_rvalid"}, 32'(bus.ld_rvalid), 32'd1);
            checkOutput({tag, "/ld_rdata"}, bus.ld_rdata, ld_q.pop_front());
        end else begin
            checkOutput({tag, "/ld_rvalid"}, 32'(bus.ld_rvalid), 32'd0);
        end
        exp_addr  = exp_cgnt ? c_addr  : (exp_lgnt ? l_addr  : 32'd0);
        exp_wdata = exp_cgnt ? c_wdata : (exp_lgnt ? l_wdata : 32'd0);
        checkOutput({tag, "/cpu_gnt"},   32'(bus.cpu_gnt),   32'(exp_cgnt));
        checkOutput({tag, "/ld_gnt"},    32'(bus.ld_gnt),    32'(exp_lgnt));
        checkOutput({tag, "/cpu_stall"}, 32'(bus.cpu_stall), 32'(c_req & ~exp_cgnt));
        checkOutput({tag, "/locked"},    32'(bus.locked),    32'(exp_locked));
        checkOutput({tag, "/mem_read"},  32'(bus.mem_read),
                    32'((exp_cgnt & ~c_we) | (exp_lgnt & ~l_we)));
        checkOutput({tag, "/mem_write"}, 32'(bus.mem_write),
                    32'((exp_cgnt & c_we) | (exp_lgnt & l_we)));
        checkOutput({tag, "/mem_addr"},  bus.mem_addr,  exp_addr);
        checkOutput({tag, "/mem_wdata"}, bus.mem_wdata, exp_wdata);
        if (exp_cgnt) begin
            if (c_we) ref_mem[c_idx] = c_wdata;
            else      cpu_q.push_back(ref_mem[c_idx]);
        end
        if (exp_lgnt) begin
            if (l_we) ref_mem[l_idx] = l_wdata;
            else      ld_q.push_back(ref_mem[l_idx]);
        end
        if (rst_at_edge) rst = 1'b1;
        @(posedge clk);
        #1;
        if (rst_at_edge) begin
            rst = 1'b0;
            cpu_q.delete();
            ld_q.delete();
        end
    endtask

    task automatic idleStep(input string tag);
        applyStimulus(tag, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0,
                      1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        test_count = 0;
        fail_count = 0;
        for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);

        rst           = 1'b1;
        preload       = 1'b1;
        bus.cpu_req   = 1'b1;
        bus.cpu_we    = 1'b0;
        bus.cpu_addr  = 32'h10;
        bus.cpu_wdata = 32'd0;
        bus.ld_req    = 1'b1;
        bus.ld_we     = 1'b1;
        bus.ld_addr   = 32'h14;
        bus.ld_wdata  = 32'hFFFF_FFFF;
        bus.ld_lock   = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checkOutput("rst/cpu_gnt",    32'(bus.cpu_gnt),    32'd0);
            checkOutput("rst/ld_gnt",     32'(bus.ld_gnt),     32'd0);
            checkOutput("rst/mem_read",   32'(bus.mem_read),   32'd0);
            checkOutput("rst/mem_write",  32'(bus.mem_write),  32'd0);
            checkOutput("rst/cpu_rvalid", 32'(bus.cpu_rvalid), 32'd0);
            checkOutput("rst/ld_rvalid",  32'(bus.ld_rvalid),  32'd0);
            checkOutput("rst/cpu_rdata",  bus.cpu_rdata,       32'd0);
            checkOutput("rst/ld_rdata",   bus.ld_rdata,        32'd0);
            checkOutput("rst/locked",     32'(bus.locked),     32'd0);
            @(posedge clk);
            #1;
        end
        rst     = 1'b0;
        preload = 1'b0;
        idleStep("idle0");

        applyStimulus("cpu_wr", 1'b1, 1'b1, 32'h10, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0,
                      1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus("cpu_rd", 1'b1, 1'b0, 32'h10, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0,
                      1'b1, 1'b0, 1'b0, 1'b0);
        idleStep("cpu_rd_ret");

        // Continuous contention: LD should break through on cycles 4 and 9.
        for (int i = 0; i < 10; i++) begin
            applyStimulus($sformatf("contend%0d", i), 1'b1, 1'b0, 32'h04, 32'd0,
                          1'b1, 1'b0, 32'h08, 32'd0, 1'b0,
                          (i != 4 && i != 9), (i == 4 || i == 9), 1'b0, 1'b0);
        end
        idleStep("contend_ret");

        for (int i = 0; i < 4; i++) begin
            applyStimulus($sformatf("sat%0d", i), 1'b1, 1'b0, 32'h0C, 32'd0,
                          1'b1, 1'b0, 32'h18, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        end
        applyStimulus("sat_drop", 1'b1, 1'b0, 32'h0C, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0,
                      1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus("sat_clear", 1'b1, 1'b0, 32'h0C, 32'd0, 1'b1, 1'b0, 32'h18, 32'd0, 1'b0,
                      1'b1, 1'b0, 1'b0, 1'b0);
        idleStep("sat_ret");

        applyStimulus("lock_arb", 1'b1, 1'b0, 32'h20, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1,
                      1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus("lock_drain", 1'b1, 1'b0, 32'h20, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1,
                      1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) begin
            applyStimulus($sformatf("lock_wr%0d", i), 1'b1, 1'b0, 32'h20, 32'd0,
                          1'b1, 1'b1, 32'(i * 4), 32'hA000_0000 | 32'(i), 1'b1,
                          1'b0, 1'b1, 1'b1, 1'b0);
        end

        applyStimulus("unlock", 1'b1, 1'b0, 32'h10, 32'd0, 1'b1, 1'b0, 32'h3C, 32'd0, 1'b0,
                      1'b0, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            applyStimulus($sformatf("post_unlock%0d", i), 1'b1, 1'b0, 32'h10, 32'd0,
                          1'b1, 1'b0, 32'h3C, 32'd0, 1'b0, (i != 4), (i == 4), 1'b0, 1'b0);
        end
        idleStep("unlock_ret");

        applyStimulus("rst_mid", 1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 32'h08, 32'd0, 1'b0,
                      1'b0, 1'b1, 1'b0, 1'b1);
        applyStimulus("after_rst", 1'b1, 1'b0, 32'h04, 32'd0, 1'b1, 1'b0, 32'h08, 32'd0, 1'b0,
                      1'b1, 1'b0, 1'b0, 1'b0);
        idleStep("final");

        $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
        $finish;
    end

endmodule
